// File: rtl/mem_access_unit.sv
// Load/store access unit: turns one core memory request into a valid/ready bus
// transaction with byte-lane strobes, returning extended load data and done/err.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT_CYCLES);

  state_t         state_q, state_d;
  logic           we_q, we_d;
  logic [2:0]     funct3_q, funct3_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    load_data_q, load_data_d;

  logic           req_illegal;
  logic [7:0]     byte_sel;
  logic [15:0]    half_sel;
  logic [31:0]    load_ext;
  logic [3:0]     lane_strb;
  logic [31:0]    lane_wdata;

  // Unsupported width codes and misaligned H/W accesses never reach the bus.
  always_comb begin
    req_illegal = 1'b0;
    if (req_we) begin
      req_illegal = (req_funct3 >= 3'd3);
    end else begin
      req_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end
    if (req_funct3[1:0] == 2'd1 && req_addr[0]) req_illegal = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0) req_illegal = 1'b1;
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_ext = {24'd0, byte_sel};
      3'd5:    load_ext = {16'd0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'd0: begin
        lane_strb  = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        lane_strb  = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_strb  = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_illegal;
          state_d  = req_illegal ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d = RESP;
          if (!we_q) load_data_d = load_ext;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (TIMEOUT_CYCLES != 0 && cnt_d == TIMEOUT_LIM) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_valid = (state_q == ACCESS);
  assign done      = (state_q == RESP);
  assign err       = (state_q == RESP) && err_q;
  assign load_data = load_data_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = lane_wdata;
  assign mem_wstrb = (state_q == ACCESS && we_q) ? lane_strb : 4'b0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a 4-cycle bus timeout.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ld;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .load_data(load_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    resetn = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end
    checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_wstrb got %b exp 0000", mem_wstrb); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data got %h exp 0", load_data); end
    exp_ld = 32'h0;
  endtask

  task automatic test_lw;
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    issue(1'b0, 3'd2, 32'h0000_0100, 32'h0);
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL lw_mem_valid got %b exp 1", mem_valid); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lw_mem_addr got %h exp 00000100", mem_addr); end
    checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL lw_wstrb got %b exp 0000", mem_wstrb); end
    checks++; if (done !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL lw_access_flags got done=%b ready=%b exp 0/0", done, req_ready); end
    tick();
    exp_ld = 32'hDEADBEEF;
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL lw_done got done=%b err=%b exp 1/0", done, err); end
    checks++; if (load_data !== exp_ld) begin errors++; $display("FAIL lw_load_data got %h exp %h", load_data, exp_ld); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL lw_resp_mem_valid got %b exp 0", mem_valid); end
    tick();
    checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL lw_idle got done=%b ready=%b exp 0/1", done, req_ready); end
  endtask

  logic [2:0]  ld_f3   [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
  logic [31:0] ld_addr [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
  logic [31:0] ld_exp  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00002233};

  task automatic test_load_ext;
    mem_ready = 1'b1; mem_rdata = 32'h80112233;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, ld_f3[i], ld_addr[i], 32'h0);
      tick();
      exp_ld = ld_exp[i];
      checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL load_ext%0d_done got done=%b err=%b exp 1/0", i, done, err); end
      checks++; if (load_data !== exp_ld) begin errors++; $display("FAIL load_ext%0d_data got %h exp %h", i, load_data, exp_ld); end
      tick();
    end
  endtask

  logic [2:0]  st_f3    [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
  logic [31:0] st_addr  [4] = '{32'h102, 32'h102, 32'h104, 32'h101};
  logic [31:0] st_wd    [4] = '{32'h000000AB, 32'h00001234, 32'hCAFEF00D, 32'h555555CD};
  logic [3:0]  st_strb  [4] = '{4'b0100, 4'b1100, 4'b1111, 4'b0010};
  logic [31:0] st_bus   [4] = '{32'hABABABAB, 32'h12341234, 32'hCAFEF00D, 32'hCDCDCDCD};
  logic [31:0] st_maddr [4] = '{32'h100, 32'h100, 32'h104, 32'h100};

  task automatic test_store;
    mem_ready = 1'b1; mem_rdata = 32'h0BADCAFE;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, st_f3[i], st_addr[i], st_wd[i]);
      checks++; if (mem_wstrb !== st_strb[i]) begin errors++; $display("FAIL store%0d_wstrb got %b exp %b", i, mem_wstrb, st_strb[i]); end
      checks++; if (mem_wdata !== st_bus[i]) begin errors++; $display("FAIL store%0d_wdata got %h exp %h", i, mem_wdata, st_bus[i]); end
      checks++; if (mem_addr !== st_maddr[i] || mem_valid !== 1'b1) begin errors++; $display("FAIL store%0d_addr got %h valid=%b exp %h valid=1", i, mem_addr, mem_valid, st_maddr[i]); end
      tick();
      checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL store%0d_done got done=%b err=%b exp 1/0", i, done, err); end
      checks++; if (load_data !== exp_ld) begin errors++; $display("FAIL store%0d_load_data got %h exp %h", i, load_data, exp_ld); end
      tick();
    end
  endtask

  logic        il_we   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0]  il_f3   [4] = '{3'd2, 3'd1, 3'd4, 3'd3};
  logic [31:0] il_addr [4] = '{32'h101, 32'h103, 32'h100, 32'h100};

  task automatic test_illegal;
    mem_ready = 1'b1; mem_rdata = 32'h77777777;
    for (int i = 0; i < 4; i++) begin
      issue(il_we[i], il_f3[i], il_addr[i], 32'h0);
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL illegal%0d_mem_valid got %b exp 0", i, mem_valid); end
      checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL illegal%0d_done got done=%b err=%b exp 1/1", i, done, err); end
      checks++; if (load_data !== exp_ld) begin errors++; $display("FAIL illegal%0d_load_data got %h exp %h", i, load_data, exp_ld); end
      tick();
      checks++; if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL illegal%0d_idle got ready=%b done=%b err=%b exp 1/0/0", i, req_ready, done, err); end
    end
  endtask

  task automatic test_timeout;
    mem_ready = 1'b0; mem_rdata = 32'h99999999;
    issue(1'b0, 3'd2, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_valid !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL timeout_wait%0d got valid=%b done=%b exp 1/0", i, mem_valid, done); end
      tick();
    end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid_drop got %b exp 0", mem_valid); end
    checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL timeout_done got done=%b err=%b exp 1/1", done, err); end
    checks++; if (load_data !== exp_ld) begin errors++; $display("FAIL timeout_load_data got %h exp %h", load_data, exp_ld); end
    tick();

    mem_rdata = 32'h12345678;
    issue(1'b0, 3'd2, 32'h100, 32'h0);
    tick(); tick(); tick();
    mem_ready = 1'b1;
    checks++; if (mem_valid !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL wait3_access got valid=%b done=%b exp 1/0", mem_valid, done); end
    tick();
    exp_ld = 32'h12345678;
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wait3_done got done=%b err=%b exp 1/0", done, err); end
    checks++; if (load_data !== exp_ld) begin errors++; $display("FAIL wait3_load_data got %h exp %h", load_data, exp_ld); end
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    mem_ready = 1'b1; mem_rdata = 32'h11111111;
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100; req_valid = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b0 || mem_addr !== 32'h100) begin errors++; $display("FAIL b2b_access got ready=%b addr=%h exp 0/00000100", req_ready, mem_addr); end
    req_addr = 32'h200;
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL b2b_addr_latched got %h exp 00000100", mem_addr); end
    tick();
    exp_ld = 32'h11111111;
    checks++; if (done !== 1'b1 || load_data !== exp_ld) begin errors++; $display("FAIL b2b_first_done got done=%b data=%h exp 1/%h", done, load_data, exp_ld); end
    tick();
    checks++; if (req_ready !== 1'b1 || mem_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got ready=%b valid=%b done=%b exp 1/0/0", req_ready, mem_valid, done); end
    mem_rdata = 32'h22222222;
    tick();
    req_valid = 1'b0;
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL b2b_second_access got valid=%b addr=%h exp 1/00000200", mem_valid, mem_addr); end
    tick();
    exp_ld = 32'h22222222;
    checks++; if (done !== 1'b1 || load_data !== exp_ld) begin errors++; $display("FAIL b2b_second_done got done=%b data=%h exp 1/%h", done, load_data, exp_ld); end
    tick();
  endtask

  task automatic test_reset_mid;
    mem_ready = 1'b0; mem_rdata = 32'h0BADF00D;
    issue(1'b0, 3'd2, 32'h300, 32'h0);
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rstmid_access got %b exp 1", mem_valid); end
    resetn = 1'b0;
    tick();
    exp_ld = 32'h0;
    checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rstmid_after got valid=%b ready=%b done=%b exp 0/1/0", mem_valid, req_ready, done); end
    resetn = 1'b1;
    tick();
    checks++; if (done !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got done=%b valid=%b exp 0/0", done, mem_valid); end
    mem_ready = 1'b1;
    issue(1'b0, 3'd2, 32'h300, 32'h0);
    tick();
    exp_ld = 32'h0BADF00D;
    checks++; if (done !== 1'b1 || err !== 1'b0 || load_data !== exp_ld) begin errors++; $display("FAIL rstmid_recover got done=%b err=%b data=%h exp 1/0/%h", done, err, load_data, exp_ld); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
